// File: rtl/pll_loop_ctrl.sv
// Digital PI loop controller for a ring-state DCO, clocked by refclk.
// Each accepted phase sample (integer pclk edge count + fractional ring state)
// is differenced against the previous one, compared with NFRAC*N, filtered by a
// saturating PI filter with anti-windup, and turned into the DCO code dctrl.
// Two-stage pipeline: stage 1 registers err, stage 2 registers accum, dctrl,
// sat and locked, with dctrl_valid pulsing in the stage-2 cycle.
//
// Ports:
//   refclk          clock (rising edge)
//   rst_n           synchronous active-low reset
//   en              loop enable; low forces IDLE, flushes the pipeline, holds dctrl/err/accum
//   sample_valid    one-cycle strobe qualifying dco_int_count / dco_frac_state
//   dco_int_count   wrapping pclk edge count (CNT_W bits)
//   dco_frac_state  fractional ring state, 0..NFRAC-1
//   dctrl           signed DCO control code (0 = centre frequency)
//   dctrl_valid     one-cycle pulse when dctrl updates
//   err             last computed signed 16-bit frequency error
//   locked          lock indicator
//   sat             last dctrl update was clamped
module pll_loop_ctrl #(
    parameter int unsigned N          = 4,
    parameter int unsigned NFRAC      = 30,
    parameter int          KP         = 500,
    parameter int          KI         = 100,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned CTRL_W     = 24,
    parameter int unsigned LOCK_TOL   = 2,
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic                     refclk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sample_valid,
    input  logic [CNT_W-1:0]         dco_int_count,
    input  logic [4:0]               dco_frac_state,
    output logic signed [CTRL_W-1:0] dctrl,
    output logic                     dctrl_valid,
    output logic signed [15:0]       err,
    output logic                     locked,
    output logic                     sat
);

    localparam int unsigned DIFF_W = CNT_W + 16;
    localparam int unsigned PROD_W = ACC_W + 24;
    localparam int unsigned LCNT_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned UCNT_W = $clog2(UNLOCK_CNT + 1);

    localparam logic signed [DIFF_W-1:0] NFRAC_S  = DIFF_W'(NFRAC);
    localparam logic signed [DIFF_W-1:0] TARGET_S = DIFF_W'(NFRAC * N);
    localparam logic signed [DIFF_W-1:0] ERR_MAX  = DIFF_W'(32767);
    localparam logic signed [DIFF_W-1:0] ERR_MIN  = ~ERR_MAX;
    localparam logic signed [15:0]       TOL_S    = 16'(LOCK_TOL);
    localparam logic signed [ACC_W:0]    ACC_MAX  = (ACC_W+1)'((64'(1) << (ACC_W - 1)) - 64'(1));
    localparam logic signed [ACC_W:0]    ACC_MIN  = ~ACC_MAX;
    localparam logic signed [PROD_W-1:0] CTRL_MAX = PROD_W'((64'(1) << (CTRL_W - 1)) - 64'(1));
    localparam logic signed [PROD_W-1:0] CTRL_MIN = ~CTRL_MAX;
    localparam logic signed [PROD_W-1:0] KP_P     = PROD_W'(KP);
    localparam logic signed [PROD_W-1:0] KI_P     = PROD_W'(KI);

    typedef enum logic [1:0] {IDLE, PRIME, ACQUIRE, LOCKED} state_t;

    state_t              state, state_next;
    logic [LCNT_W-1:0]   in_cnt, in_cnt_next;
    logic [UCNT_W-1:0]   out_cnt, out_cnt_next;
    logic                prime, s1_load, s2_load;

    logic [CNT_W-1:0]    int_prev;
    logic [4:0]          frac_prev;
    logic                s1_valid;
    logic signed [ACC_W-1:0] accum;
    logic                sat_neg;

    logic [CNT_W-1:0]          dint;
    logic signed [DIFF_W-1:0]  diff, err_wide;
    logic signed [15:0]        err_new;
    logic                      in_tol, hold;
    logic signed [ACC_W:0]     acc_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [PROD_W-1:0]  prod, prod_clamp;
    logic                      clamp_hi, clamp_lo;

    // Stage 1: phase difference and saturated frequency error
    always_comb begin
        dint     = dco_int_count - int_prev;
        diff     = NFRAC_S * $signed(DIFF_W'(dint))
                 + $signed(DIFF_W'(dco_frac_state)) - $signed(DIFF_W'(frac_prev));
        err_wide = TARGET_S - diff;
        if (err_wide > ERR_MAX) begin
            err_new = 16'sh7fff;
        end else if (err_wide < ERR_MIN) begin
            err_new = 16'sh8000;
        end else begin
            err_new = 16'(err_wide);
        end
    end

    // Stage 2: PI filter; integrator freezes while pushing further into the active clamp
    always_comb begin
        in_tol   = (err <= TOL_S) && (err >= -TOL_S);
        hold     = sat && (sat_neg ? (err < 16'sd0) : (err > 16'sd0));
        acc_sum  = $signed((ACC_W+1)'(accum)) + $signed((ACC_W+1)'(err));
        if (hold) begin
            acc_next = accum;
        end else if (acc_sum > ACC_MAX) begin
            acc_next = ACC_W'(ACC_MAX);
        end else if (acc_sum < ACC_MIN) begin
            acc_next = ACC_W'(ACC_MIN);
        end else begin
            acc_next = ACC_W'(acc_sum);
        end
        prod     = KP_P * PROD_W'(err) + KI_P * PROD_W'(acc_next);
        clamp_hi = prod > CTRL_MAX;
        clamp_lo = prod < CTRL_MIN;
        if (clamp_hi) begin
            prod_clamp = CTRL_MAX;
        end else if (clamp_lo) begin
            prod_clamp = CTRL_MIN;
        end else begin
            prod_clamp = prod;
        end
    end

    // FSM state and lock streak counters
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state   <= state_next;
            in_cnt  <= in_cnt_next;
            out_cnt <= out_cnt_next;
        end
    end

    // Next state, streak counting and pipeline load enables; en low overrides all
    always_comb begin
        state_next   = state;
        in_cnt_next  = in_cnt;
        out_cnt_next = out_cnt;
        prime        = 1'b0;
        s1_load      = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = PRIME;
            end
            PRIME: begin
                if (sample_valid) begin
                    prime      = 1'b1;
                    state_next = ACQUIRE;
                end
            end
            ACQUIRE: begin
                s1_load = sample_valid;
                if (s1_valid) begin
                    if (!in_tol) begin
                        in_cnt_next = '0;
                    end else if (in_cnt == LCNT_W'(LOCK_CNT - 1)) begin
                        in_cnt_next  = '0;
                        out_cnt_next = '0;
                        state_next   = LOCKED;
                    end else begin
                        in_cnt_next = in_cnt + LCNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                s1_load = sample_valid;
                if (s1_valid) begin
                    if (in_tol) begin
                        out_cnt_next = '0;
                    end else if (out_cnt == UCNT_W'(UNLOCK_CNT - 1)) begin
                        in_cnt_next  = '0;
                        out_cnt_next = '0;
                        state_next   = ACQUIRE;
                    end else begin
                        out_cnt_next = out_cnt + UCNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (!en) begin
            state_next   = IDLE;
            in_cnt_next  = '0;
            out_cnt_next = '0;
            prime        = 1'b0;
            s1_load      = 1'b0;
        end
    end

    assign s2_load = s1_valid && en;

    // Datapath registers for both pipeline stages
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            int_prev    <= '0;
            frac_prev   <= '0;
            s1_valid    <= 1'b0;
            err         <= '0;
            accum       <= '0;
            dctrl       <= '0;
            sat         <= 1'b0;
            sat_neg     <= 1'b0;
            dctrl_valid <= 1'b0;
            locked      <= 1'b0;
        end else begin
            if (prime || s1_load) begin
                int_prev  <= dco_int_count;
                frac_prev <= dco_frac_state;
            end
            s1_valid <= s1_load;
            if (s1_load) err <= err_new;
            dctrl_valid <= s2_load;
            if (s2_load) begin
                accum   <= acc_next;
                dctrl   <= CTRL_W'(prod_clamp);
                sat     <= clamp_hi || clamp_lo;
                sat_neg <= clamp_lo;
            end
            locked <= (state_next == LOCKED);
        end
    end

endmodule

// File: doc/pll_loop_ctrl.md
# pll_loop_ctrl

Synthesizable digital loop controller for the ring-state DCO, running in the `refclk` domain. Each reference edge it takes the sampled DCO phase (integer `pclk` edge count plus 30-state fractional ring state), forms the frequency error against `N` DCO cycles, runs a saturating PI filter, and drives the DCO control code `dctrl`. It also reports lock. It is the control end of the DCO interface: the DCO consumes `dctrl` and produces the phase samples.

## Interface

Parameters:
- `N`, 4: target DCO cycles per `refclk` period.
- `NFRAC`, 30: fractional states per DCO cycle. Sample `frac` range is 0..NFRAC-1.
- `KP`, 500: proportional gain, integer.
- `KI`, 100: integral gain, integer.
- `CNT_W`, 16: width of the wrapping integer edge counter.
- `ACC_W`, 32: integrator width, signed.
- `CTRL_W`, 24: `dctrl` width, signed.
- `LOCK_TOL`, 2: maximum |err| that counts as in-lock.
- `LOCK_CNT`, 64: number of consecutive in-tolerance samples required to declare lock.
- `UNLOCK_CNT`, 4: number of consecutive out-of-tolerance samples required to drop lock.

Ports:
- `refclk`, input, 1: the only clock. All logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `en`, input, 1: loop enable.
- `sample_valid`, input, 1: one-cycle strobe. It marks `dco_int_count` and `dco_frac_state` as valid.
- `dco_int_count`, input, CNT_W: `pclk` rising-edge count. It is already synchronized and wraps mod 2^CNT_W.
- `dco_frac_state`, input, 5: ring fractional state, 0..NFRAC-1.
- `dctrl`, output, CTRL_W signed: DCO control code. 0 means the F0 centre frequency.
- `dctrl_valid`, output, 1: one-cycle pulse when `dctrl` updates.
- `err`, output, 16 signed: the last computed frequency error.
- `locked`, output, 1: lock indicator.
- `sat`, output, 1: high when the last `dctrl` update was clamped.

## Operation

- FSM states: IDLE, PRIME, ACQUIRE, LOCKED.
  - Reset → IDLE.
  - IDLE → PRIME when `en` = 1.
  - PRIME: the first `sample_valid` only stores (int, frac) as the previous sample. No err, no `dctrl_valid`. Then → ACQUIRE.
  - ACQUIRE → LOCKED after LOCK_CNT consecutive samples with |err| ≤ LOCK_TOL.
  - LOCKED → ACQUIRE after UNLOCK_CNT consecutive samples with |err| > LOCK_TOL.
  - Any state → IDLE when `en` = 0.
- Both the in-lock and out-of-lock counters reset on any sample that breaks their streak. Both also clear on entry to IDLE.
- Phase difference:
  - dint = (int − int_prev) mod 2^CNT_W, treated as unsigned.
  - diff = NFRAC·dint + (frac − frac_prev), signed and at least 24 bits wide.
- err = NFRAC·N − diff, saturated to signed 16 bits.
- Integrator: accum_next = accum + err, saturated to ACC_W.
  - Anti-windup: accum holds if the previous `dctrl` was saturated and err has the same sign as the saturation.
- dctrl = KP·err + KI·accum_next. Compute at ≥ 48 bits, then clamp to [−2^(CTRL_W−1), 2^(CTRL_W−1)−1]. `sat` = 1 when clamped.
- `en` low:
  - State → IDLE and `locked` → 0.
  - `dctrl`, `err` and accum hold their values.
  - Re-enable passes through PRIME (warm restart with accum retained).
- Only `rst_n` clears accum.

## Timing

- Reset values: `dctrl` = 0, `dctrl_valid` = 0, `err` = 0, `locked` = 0, `sat` = 0. accum = 0, counters = 0, state = IDLE.
- Two-stage pipeline. For `sample_valid` in cycle t:
  - Stage 1 registers diff/err; `err` is visible at t+1.
  - Stage 2 registers accum, `dctrl`, `sat`, `locked`; `dctrl_valid` = 1 in cycle t+2 only.
- Back-to-back `sample_valid` on consecutive cycles is supported at full throughput.
- `en` falling in the same cycle as `sample_valid`: the sample is dropped. Samples already in flight in the pipeline are flushed and produce no `dctrl_valid`.
- `rst_n` low mid-pipeline: all in-flight samples are discarded. Reset values apply on the next edge.
- `locked` changes in the same cycle as the `dctrl_valid` of the deciding sample.
- Inputs are sampled only when `sample_valid` = 1. `frac` ≥ NFRAC is illegal and its behaviour is unspecified.

## Test plan

- Reset: hold `rst_n` = 0 with random inputs → all outputs 0. `en` = 1 with a single sample → no `dctrl_valid`; the sample only primes.
- Nominal: samples (0,0) then (4,0) → `err` = 0, `dctrl` = 0, `dctrl_valid` exactly 2 cycles after the second strobe.
- Fast DCO: (0,0) then (4,10) → diff = 130, `err` = −10, accum = −10, `dctrl` = −6000, `sat` = 0.
- Counter wrap: (65534,20) then (2,20) → dint = 4, `err` = 0, `dctrl` unchanged.
- Lock:
  - 64 consecutive samples with `err` = 0 → `locked` rises with the 64th `dctrl_valid`.
  - Then 3 samples with `err` = 5 → `locked` stays 1; the 4th → `locked` = 0.
  - One in-tolerance sample in between restarts the unlock count.
- Saturation/enable: repeated `err` = −32768 → `dctrl` = −8388608, `sat` = 1, accum frozen. Drop `en` with a sample in flight → no `dctrl_valid`, `dctrl` held, `locked` = 0. Re-enable → first sample only primes.
